// File: rtl/updown_counter_sequencer_if.sv
// Command channel for the up/down counter sequencer: a valid/ready
// handshake carrying the run mode, the step interval and the step count.
interface updown_counter_sequencer_if #(
  parameter int PRESCALE_W = 16,
  parameter int STEPS_W    = 8
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_mode;
  logic [PRESCALE_W-1:0] cmd_div;
  logic [STEPS_W-1:0]    cmd_steps;

  // Command source: offers commands and observes ready
  modport master (
    output cmd_valid, cmd_mode, cmd_div, cmd_steps,
    input  cmd_ready
  );

  // Sequencer side: accepts commands and reports ready
  modport slave (
    input  cmd_valid, cmd_mode, cmd_div, cmd_steps,
    output cmd_ready
  );
endinterface

// File: rtl/updown_counter_sequencer.sv
// Sequencer for the 2-bit up/down counter datapath. Accepts a run command,
// paces step strobes with a prescaler, picks the step direction according to
// the run mode and ends the run after a programmed step count or on stop.
module updown_counter_sequencer #(
  parameter int PRESCALE_W = 16,
  parameter int STEPS_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  updown_counter_sequencer_if.slave    cmd,
  input  logic                         stop,
  input  logic [1:0]                   cnt_value,
  output logic                         cnt_step,
  output logic                         cnt_dir,
  output logic                         busy,
  output logic                         done,
  output logic                         wrap
);

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [PRESCALE_W-1:0] prescaler_q, prescaler_d;
  logic [STEPS_W-1:0]    remaining_q, remaining_d;
  logic                  unlimited_q, unlimited_d;
  logic                  dir_q, dir_d;

  // Direction the next step would take; bounce reverses at the end stops
  // and otherwise keeps the direction of the previous step.
  logic dir_sel;
  always_comb begin
    dir_sel = dir_q;
    case (mode_q)
      MODE_UP:     dir_sel = 1'b0;
      MODE_DOWN:   dir_sel = 1'b1;
      MODE_BOUNCE: begin
        if (cnt_value == 2'd3)      dir_sel = 1'b1;
        else if (cnt_value == 2'd0) dir_sel = 1'b0;
        else                        dir_sel = dir_q;
      end
      default:     dir_sel = dir_q;
    endcase
  end

  // Next-state and output decode: handshake in IDLE, pacing and step-count
  // bookkeeping in RUN (stop overrides any step due that cycle), pulse in DONE.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    div_d       = div_q;
    prescaler_d = prescaler_q;
    remaining_d = remaining_q;
    unlimited_d = unlimited_q;
    dir_d       = dir_q;
    cmd.cmd_ready = 1'b0;
    cnt_step    = 1'b0;
    cnt_dir     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    wrap        = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (cmd.cmd_valid) begin
          mode_d      = cmd.cmd_mode;
          div_d       = cmd.cmd_div;
          remaining_d = cmd.cmd_steps;
          unlimited_d = (cmd.cmd_steps == '0);
          prescaler_d = '0;
          dir_d       = (cmd.cmd_mode == MODE_DOWN);
          state_d     = S_RUN;
        end
      end

      S_RUN: begin
        busy = 1'b1;
        if (stop) begin
          prescaler_d = '0;
          remaining_d = '0;
          state_d     = S_IDLE;
        end else if (mode_q != MODE_HOLD) begin
          if (prescaler_q == div_q) begin
            prescaler_d = '0;
            cnt_step    = 1'b1;
            cnt_dir     = dir_sel;
            dir_d       = dir_sel;
            wrap        = ((mode_q == MODE_UP)   && (cnt_value == 2'd3)) ||
                          ((mode_q == MODE_DOWN) && (cnt_value == 2'd0));
            if (!unlimited_q && (remaining_q != '0)) begin
              remaining_d = remaining_q - 1'b1;
              if (remaining_q == STEPS_W'(1)) state_d = S_DONE;
            end
          end else begin
            prescaler_d = prescaler_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset abandons any run at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_UP;
      div_q       <= '0;
      prescaler_q <= '0;
      remaining_q <= '0;
      unlimited_q <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      div_q       <= div_d;
      prescaler_q <= prescaler_d;
      remaining_q <= remaining_d;
      unlimited_q <= unlimited_d;
      dir_q       <= dir_d;
    end
  end

endmodule
